// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 1 start bit, DBIT data bits LSB first, no parity, 1 stop bit.
// Each bit is sampled at its midpoint; the result is delivered with a one-cycle done strobe.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [2:0] NLast = 3'(DBIT - 1);
    localparam logic [3:0] SStop = 4'(SB_TICK - 1);

    state_e          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                // Start edge is taken without waiting for a tick.
                if (!rx_s) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == NLast) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    // Back to idle mid stop bit so an immediate next start edge is caught.
                    if (s_q == SStop) begin
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8-bit and a 7-bit instance driven by one tick generator;
// expected words go into per-instance queues and are compared when rx_done_tick fires.
`timescale 1ns / 1ps
module tb_uart_rx;

    localparam int TDIV = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic [7:0] dout8;
    logic [6:0] dout7;
    logic       done8, done7, ferr8, ferr7;

    bit tick_en = 1'b1;
    int div_cnt = 0;
    int tick_total = 0;
    int checks = 0;
    int failures = 0;
    int done_cnt8 = 0;
    int done_cnt7 = 0;
    int t8[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    vec_t vecs[4];
    exp_t q8[$];
    exp_t q7[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx8),
        .dout(dout8), .rx_done_tick(done8), .frame_err(ferr8)
    );

    uart_rx #(.DBIT(7), .SB_TICK(16)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx7),
        .dout(dout7), .rx_done_tick(done7), .frame_err(ferr7)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (tick_en && div_cnt == TDIV - 1) begin
                tick = 1'b1;
                div_cnt = 0;
                tick_total++;
            end else begin
                tick = 1'b0;
                if (tick_en) div_cnt++;
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            done_cnt8++;
            t8.push_back(tick_total);
            if (q8.size() == 0) begin
                check("unexpected_done8", {24'd0, dout8}, 32'hFFFF_FFFF);
            end else begin
                e = q8.pop_front();
                check("dout8", {24'd0, dout8}, {24'd0, e.d});
                check("ferr8", {31'd0, ferr8}, {31'd0, e.fe});
            end
        end
        if (done7) begin
            done_cnt7++;
            if (q7.size() == 0) begin
                check("unexpected_done7", {25'd0, dout7}, 32'hFFFF_FFFF);
            end else begin
                e = q7.pop_front();
                check("dout7", {25'd0, dout7}, {24'd0, e.d});
                check("ferr7", {31'd0, ferr7}, {31'd0, e.fe});
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick);
        end
    endtask

    task automatic set_rx(input bit sel, input logic b);
        @(negedge clk);
        if (sel) rx7 = b;
        else rx8 = b;
    endtask

    task automatic drive_bit(input bit sel, input logic b, input bit pause);
        set_rx(sel, b);
        if (pause) begin
            wait_ticks(8);
            tick_en = 1'b0;
            repeat (5000) @(posedge clk);
            tick_en = 1'b1;
            wait_ticks(8);
        end else begin
            wait_ticks(16);
        end
    endtask

    // A low stop bit is held only past its sample point, so the line is high again
    // before the receiver's next start-bit check.
    task automatic send_frame(input bit sel, input logic [7:0] data, input int nbits,
                              input logic stop, input int pause_bit);
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], i == pause_bit);
        if (stop) begin
            drive_bit(sel, 1'b1, 1'b0);
        end else begin
            set_rx(sel, 1'b0);
            wait_ticks(12);
            set_rx(sel, 1'b1);
            wait_ticks(4);
        end
    endtask

    initial begin
        int c0;
        int d1;
        int d2;
        vecs[0] = '{data: 8'h55, stop: 1'b1, glitch: 1'b0, exp_dout: 8'h55, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'hC3, stop: 1'b1, glitch: 1'b1, exp_dout: 8'hC3, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hA3, stop: 1'b0, glitch: 1'b0, exp_dout: 8'hA3, exp_ferr: 1'b1};
        vecs[3] = '{data: 8'h01, stop: 1'b1, glitch: 1'b0, exp_dout: 8'h01, exp_ferr: 1'b0};

        repeat (5) @(negedge clk);
        check("reset_dout8", {24'd0, dout8}, 32'd0);
        check("reset_ferr8", {31'd0, ferr8}, 32'd0);
        check("reset_done8", {31'd0, done8}, 32'd0);
        check("reset_dout7", {25'd0, dout7}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(32);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].glitch) begin
                c0 = done_cnt8;
                set_rx(1'b0, 1'b0);
                wait_ticks(4);
                set_rx(1'b0, 1'b1);
                wait_ticks(32);
                check("glitch_no_done", done_cnt8, c0);
            end
            q8.push_back('{d: vecs[i].exp_dout, fe: vecs[i].exp_ferr});
            c0 = done_cnt8;
            send_frame(1'b0, vecs[i].data, 8, vecs[i].stop, -1);
            wait_ticks(32);
            check("done_once", done_cnt8, c0 + 1);
            if (i == 0) begin
                repeat (1000) @(posedge clk);
                @(negedge clk);
                check("dout_held", {24'd0, dout8}, 32'h55);
            end
        end

        // Reset during data bit 4 of 0x0F.
        c0 = done_cnt8;
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, 1'b0);
        set_rx(1'b0, 1'b0);
        wait_ticks(8);
        @(negedge clk);
        rst_n = 1'b0;
        rx8 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", done_cnt8, c0);
        check("rst_mid_dout", {24'd0, dout8}, 32'd0);
        check("rst_mid_ferr", {31'd0, ferr8}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(32);
        check("rst_mid_still_no_done", done_cnt8, c0);
        q8.push_back('{d: 8'h0F, fe: 1'b0});
        send_frame(1'b0, 8'h0F, 8, 1'b1, -1);
        wait_ticks(32);
        check("after_rst_done", done_cnt8, c0 + 1);

        // Back-to-back frames with no idle gap.
        c0 = done_cnt8;
        q8.push_back('{d: 8'h00, fe: 1'b0});
        q8.push_back('{d: 8'hFF, fe: 1'b0});
        q8.push_back('{d: 8'h80, fe: 1'b0});
        send_frame(1'b0, 8'h00, 8, 1'b1, -1);
        send_frame(1'b0, 8'hFF, 8, 1'b1, -1);
        send_frame(1'b0, 8'h80, 8, 1'b1, -1);
        wait_ticks(32);
        check("b2b_done_count", done_cnt8, c0 + 3);
        if (t8.size() >= 3) begin
            d1 = t8[t8.size()-2] - t8[t8.size()-3];
            d2 = t8[t8.size()-1] - t8[t8.size()-2];
            check("b2b_gap1_160", (d1 >= 158 && d1 <= 162) ? 32'd1 : 32'd0, 32'd1);
            check("b2b_gap2_160", (d2 >= 158 && d2 <= 162) ? 32'd1 : 32'd0, 32'd1);
        end else begin
            check("b2b_gap_samples", t8.size(), 32'd3);
        end

        // 7-bit instance: plain frame, then one with ticks stalled mid data bit 3.
        c0 = done_cnt7;
        q7.push_back('{d: 8'h35, fe: 1'b0});
        send_frame(1'b1, 8'h35, 7, 1'b1, -1);
        wait_ticks(32);
        check("d7_done_once", done_cnt7, c0 + 1);
        c0 = done_cnt7;
        q7.push_back('{d: 8'h5A, fe: 1'b0});
        send_frame(1'b1, 8'h5A, 7, 1'b1, 3);
        wait_ticks(32);
        check("d7_pause_done_once", done_cnt7, c0 + 1);

        check("q8_drained", q8.size(), 32'd0);
        check("q7_drained", q7.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
